// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared FSM state encodings and index-width helper for the divider arbiter
package div_arb_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
  typedef enum logic [1:0] {C_IDLE, C_OP, C_LAST, C_DONE} core_state_t;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/div_core.sv
// div_core: iterative restoring unsigned divider; done_tick rises W+2 cycles after start is sampled
import div_arb_pkg::*;
module div_core #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dvnd,
  input  logic [W-1:0] dvsr,
  output logic         ready,
  output logic         done_tick,
  output logic [W-1:0] quo,
  output logic [W-1:0] rmd
);
  localparam int CW = $clog2(W + 1);
  core_state_t  state;
  logic [W-1:0] rh, rl, d;
  logic [CW-1:0] n;
  logic [W:0]   sh;
  logic         ge;
  assign sh        = {rh, rl[W-1]};
  assign ge        = sh >= {1'b0, d};
  assign ready     = state == C_IDLE;
  assign done_tick = state == C_DONE;
  assign quo       = rl;
  assign rmd       = rh;
  // one shift-subtract step per cycle, then a spacer cycle and a one-cycle done state
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= C_IDLE;
      rh    <= '0;
      rl    <= '0;
      d     <= '0;
      n     <= '0;
    end else begin
      case (state)
        C_IDLE: if (start) begin
          rh    <= '0;
          rl    <= dvnd;
          d     <= dvsr;
          n     <= CW'(W);
          state <= C_OP;
        end
        C_OP: begin
          rh <= ge ? W'(sh - {1'b0, d}) : sh[W-1:0];
          rl <= {rl[W-2:0], ge};
          n  <= n - CW'(1);
          if (n == CW'(1)) state <= C_LAST;
        end
        C_LAST:  state <= C_DONE;
        default: state <= C_IDLE;
      endcase
    end
endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one divider among N requesters; DIV_ZERO_CHK_EN short-circuits divide-by-zero jobs
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req,
  input  logic [N*W-1:0]         dvnd_in,
  input  logic [N*W-1:0]         dvsr_in,
  output logic [N-1:0]           ack,
  output logic [N-1:0]           done,
  output logic [W-1:0]           quo,
  output logic [W-1:0]           rmd,
  output logic [idx_w(N)-1:0]    owner,
  output logic                   busy,
  output logic                   err
);
  localparam int IDX_W = idx_w(N);
  state_t           state;
  logic [IDX_W-1:0] ptr, win;
  logic             found, start, core_ready, core_done;
  logic [W-1:0]     dvnd_r, dvsr_r, core_quo, core_rmd, win_dvnd, win_dvsr;

  function automatic logic [IDX_W:0] pick(input logic [N-1:0] r, input logic [IDX_W-1:0] p);
    logic [IDX_W:0] res;
    int j;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(p) + k) % N;
      if (r[j]) res = {1'b1, IDX_W'(j)};
    end
    return res;
  endfunction

  // first requesting index at or after the priority pointer, wrapping
  always_comb {found, win} = pick(req, ptr);

  assign win_dvnd = dvnd_in[int'(win)*W +: W];
  assign win_dvsr = dvsr_in[int'(win)*W +: W];
  assign busy     = state != IDLE;

  // arbitration FSM with registered ack/done/start pulses and held results
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      dvnd_r <= '0;
      dvsr_r <= '0;
      ack    <= '0;
      done   <= '0;
      start  <= 1'b0;
      quo    <= '0;
      rmd    <= '0;
      err    <= 1'b0;
    end else begin
      ack   <= '0;
      done  <= '0;
      start <= 1'b0;
      case (state)
        IDLE: if (found && core_ready) begin
          owner    <= win;
          dvnd_r   <= win_dvnd;
          dvsr_r   <= win_dvsr;
          ack[win] <= 1'b1;
`ifdef DIV_ZERO_CHK_EN
          if (win_dvsr == '0) begin
            done[win] <= 1'b1;
            quo       <= '1;
            rmd       <= win_dvnd;
            err       <= 1'b1;
            state     <= DONE;
          end else begin
            start <= 1'b1;
            state <= LAUNCH;
          end
`else
          start <= 1'b1;
          state <= LAUNCH;
`endif
        end
        LAUNCH: state <= WAIT;
        WAIT: if (core_done) begin
          quo         <= core_quo;
          rmd         <= core_rmd;
          err         <= 1'b0;
          done[owner] <= 1'b1;
          state       <= DONE;
        end
        default: begin
          ptr   <= (owner == IDX_W'(N - 1)) ? '0 : owner + IDX_W'(1);
          state <= IDLE;
        end
      endcase
    end

  div_core #(.W(W)) u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dvnd      (dvnd_r),
    .dvsr      (dvsr_r),
    .ready     (core_ready),
    .done_tick (core_done),
    .quo       (core_quo),
    .rmd       (core_rmd)
  );
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed self-checking bench for div_arbiter (W=8, N=4); define DIV_ZERO_CHK_EN to add the zero-divisor test
module tb_div_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] dvnd_in = '0;
  logic [31:0] dvsr_in = '0;
  logic [3:0]  ack, done;
  logic [7:0]  quo, rmd;
  logic [1:0]  owner;
  logic        busy, err;
  int errors = 0;
  int checks = 0;

  div_arbiter #(.W(8), .N(4)) dut (
    .clk(clk), .reset(reset), .req(req), .dvnd_in(dvnd_in), .dvsr_in(dvsr_in),
    .ack(ack), .done(done), .quo(quo), .rmd(rmd), .owner(owner), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // issue one job on requester i from an idle cycle; swap operands to a2/b2 and drop req once acked
  task automatic run_job(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] a2, input logic [7:0] b2,
                         output int ac, output int dc, output logic [3:0] av,
                         output logic [3:0] dv, output int ov);
    @(negedge clk);
    for (int k = 0; k < 30 && busy; k++) @(negedge clk);
    dvnd_in[i*8 +: 8] = a;
    dvsr_in[i*8 +: 8] = b;
    req[i] = 1'b1;
    ac = -1; dc = -1; av = '0; dv = '0; ov = 0;
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      @(posedge clk); #1;
      if ((ack & done) != 4'b0) ov++;
      if (ack != 4'b0 && ac < 0) begin
        ac = c; av = ack; req[i] = 1'b0;
        dvnd_in[i*8 +: 8] = a2;
        dvsr_in[i*8 +: 8] = b2;
      end
      if (done != 4'b0) begin dc = c; dv = done; end
    end
    req[i] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
    checks++; if (done !== 4'b0) begin errors++; $display("FAIL reset_done: got %b expected 0000", done); end
    checks++; if ({quo, rmd} !== 16'h0) begin errors++; $display("FAIL reset_result: got quo=%0d rmd=%0d expected 0 0", quo, rmd); end
    checks++; if ({owner, busy, err} !== 4'b0) begin errors++; $display("FAIL reset_state: got owner=%0d busy=%b err=%b expected 0 0 0", owner, busy, err); end
    reset = 1'b1;
  endtask

  task automatic test_single();
    int ac, dc, ov;
    logic [3:0] av, dv;
    run_job(0, 8'd200, 8'd7, 8'd200, 8'd7, ac, dc, av, dv, ov);
    checks++; if (ac !== 1) begin errors++; $display("FAIL single_ack_cycle: got %0d expected 1", ac); end
    checks++; if (dc !== 12) begin errors++; $display("FAIL single_done_cycle: got %0d expected 12", dc); end
    checks++; if (av !== 4'b0001) begin errors++; $display("FAIL single_ack_bits: got %b expected 0001", av); end
    checks++; if (dv !== 4'b0001) begin errors++; $display("FAIL single_done_bits: got %b expected 0001", dv); end
    checks++; if (quo !== 8'd28) begin errors++; $display("FAIL single_quo: got %0d expected 28", quo); end
    checks++; if (rmd !== 8'd4) begin errors++; $display("FAIL single_rmd: got %0d expected 4", rmd); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL single_owner: got %0d expected 0", owner); end
    checks++; if (ov !== 0) begin errors++; $display("FAIL single_ack_done_overlap: got %0d expected 0", ov); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_after_done: got busy=%b expected 0", busy); end
    checks++; if ({quo, rmd} !== {8'd28, 8'd4}) begin errors++; $display("FAIL single_hold: got quo=%0d rmd=%0d expected 28 4", quo, rmd); end
  endtask

  task automatic test_fairness();
    logic [3:0] order [5];
    int cyc [5];
    logic [3:0] exp_order [5];
    int n = 0;
    int ov = 0;
    logic [7:0] q0 = '0;
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      dvnd_in[i*8 +: 8] = 8'(20 + i*10);
      dvsr_in[i*8 +: 8] = 8'd2;
    end
    req = 4'b1111;
    for (int c = 1; c <= 100 && n < 5; c++) begin
      @(posedge clk); #1;
      if ((ack & done) != 4'b0) ov++;
      if (done != 4'b0) begin
        if (n == 0) q0 = quo;
        order[n] = done; cyc[n] = c; n++;
      end
    end
    req = '0;
    checks++; if (n !== 5) begin errors++; $display("FAIL fair_count: got %0d expected 5", n); end
    for (int k = 0; k < n; k++) begin
      checks++; if (order[k] !== exp_order[k]) begin errors++; $display("FAIL fair_order[%0d]: got %b expected %b", k, order[k], exp_order[k]); end
      checks++; if (cyc[k] !== 12 + 13*k) begin errors++; $display("FAIL fair_cycle[%0d]: got %0d expected %0d", k, cyc[k], 12 + 13*k); end
    end
    checks++; if (q0 !== 8'd10) begin errors++; $display("FAIL fair_first_quo: got %0d expected 10", q0); end
    checks++; if (ov !== 0) begin errors++; $display("FAIL fair_ack_done_overlap: got %0d expected 0", ov); end
  endtask

  task automatic test_operand_change();
    int ac, dc, ov;
    logic [3:0] av, dv;
    run_job(2, 8'd100, 8'd9, 8'd5, 8'd5, ac, dc, av, dv, ov);
    checks++; if (dv !== 4'b0100) begin errors++; $display("FAIL opchg_done_bits: got %b expected 0100", dv); end
    checks++; if ({quo, rmd} !== {8'd11, 8'd1}) begin errors++; $display("FAIL opchg_result: got quo=%0d rmd=%0d expected 11 1", quo, rmd); end
    checks++; if (owner !== 2'd2) begin errors++; $display("FAIL opchg_owner: got %0d expected 2", owner); end
  endtask

  task automatic test_edges();
    logic [7:0] a [3] = '{8'd255, 8'd5, 8'd255};
    logic [7:0] b [3] = '{8'd1, 8'd200, 8'd255};
    logic [7:0] eq [3] = '{8'd255, 8'd0, 8'd1};
    logic [7:0] er [3] = '{8'd0, 8'd5, 8'd0};
    int ac, dc, ov;
    logic [3:0] av, dv;
    for (int k = 0; k < 3; k++) begin
      run_job(1, a[k], b[k], a[k], b[k], ac, dc, av, dv, ov);
      checks++; if (dc !== 12) begin errors++; $display("FAIL edge%0d_done_cycle: got %0d expected 12", k, dc); end
      checks++; if ({quo, rmd} !== {eq[k], er[k]}) begin errors++; $display("FAIL edge%0d_result: got quo=%0d rmd=%0d expected %0d %0d", k, quo, rmd, eq[k], er[k]); end
    end
  endtask

  task automatic test_reset_mid_wait();
    int ac, dc, ov, nd;
    logic [3:0] av, dv, first_ack;
    run_job(1, 8'd50, 8'd7, 8'd50, 8'd7, ac, dc, av, dv, ov);
    checks++; if ({quo, rmd} !== {8'd7, 8'd1}) begin errors++; $display("FAIL prereset_result: got quo=%0d rmd=%0d expected 7 1", quo, rmd); end
    @(negedge clk);
    for (int k = 0; k < 30 && busy; k++) @(negedge clk);
    dvnd_in[7:0] = 8'd90;
    dvsr_in[7:0] = 8'd4;
    req = 4'b0001;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) req = '0;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midwait_busy: got %b expected 1", busy); end
    reset = 1'b0;
    #1;
    checks++; if ({ack, done} !== 8'h0) begin errors++; $display("FAIL midwait_pulses: got ack=%b done=%b expected 0000 0000", ack, done); end
    checks++; if ({quo, rmd} !== 16'h0) begin errors++; $display("FAIL midwait_result: got quo=%0d rmd=%0d expected 0 0", quo, rmd); end
    checks++; if ({owner, busy, err} !== 4'b0) begin errors++; $display("FAIL midwait_state: got owner=%0d busy=%b err=%b expected 0 0 0", owner, busy, err); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    nd = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done != 4'b0) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL midwait_no_done: got %0d pulses expected 0", nd); end
    @(negedge clk);
    dvnd_in[15:8] = 8'd9;  dvsr_in[15:8] = 8'd2;
    dvnd_in[31:24] = 8'd9; dvsr_in[31:24] = 8'd3;
    req = 4'b1010;
    first_ack = '0;
    for (int c = 1; c <= 20 && first_ack == 4'b0; c++) begin
      @(posedge clk); #1;
      if (ack != 4'b0) begin first_ack = ack; req = '0; end
    end
    req = '0;
    checks++; if (first_ack !== 4'b0010) begin errors++; $display("FAIL postreset_ptr: got ack=%b expected 0010", first_ack); end
    run_job(2, 8'd100, 8'd10, 8'd100, 8'd10, ac, dc, av, dv, ov);
    checks++; if (dv !== 4'b0100) begin errors++; $display("FAIL postreset_done_bits: got %b expected 0100", dv); end
    checks++; if ({owner, quo, rmd} !== {2'd2, 8'd10, 8'd0}) begin errors++; $display("FAIL postreset_result: got owner=%0d quo=%0d rmd=%0d expected 2 10 0", owner, quo, rmd); end
  endtask

`ifdef DIV_ZERO_CHK_EN
  task automatic test_div_zero();
    int ac, dc, ov;
    logic [3:0] av, dv;
    run_job(3, 8'd77, 8'd0, 8'd77, 8'd0, ac, dc, av, dv, ov);
    checks++; if ({ac, dc} !== {32'sd1, 32'sd1}) begin errors++; $display("FAIL dz_cycles: got ack=%0d done=%0d expected 1 1", ac, dc); end
    checks++; if ({av, dv} !== 8'b1000_1000) begin errors++; $display("FAIL dz_bits: got ack=%b done=%b expected 1000 1000", av, dv); end
    checks++; if ({quo, rmd, err} !== {8'd255, 8'd77, 1'b1}) begin errors++; $display("FAIL dz_result: got quo=%0d rmd=%0d err=%b expected 255 77 1", quo, rmd, err); end
    run_job(3, 8'd10, 8'd3, 8'd10, 8'd3, ac, dc, av, dv, ov);
    checks++; if ({quo, rmd, err} !== {8'd3, 8'd1, 1'b0}) begin errors++; $display("FAIL dz_clear: got quo=%0d rmd=%0d err=%b expected 3 1 0", quo, rmd, err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_operand_change();
    test_edges();
    test_reset_mid_wait();
`ifdef DIV_ZERO_CHK_EN
    test_div_zero();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
Shares one iterative unsigned divider between N independent requesters. Uses round-robin arbitration, with one division in flight at a time. Captures the winner's operands, sequences the divider core, and returns quotient/remainder with a per-requester done pulse. Sits between the MCS-side I/O slots and a single divider instance.

Parameters:
W, 8, operand/result width in bits (W >= 2)
N, 4, number of requesters (N >= 2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  N  per-requester request level; held until matching ack
dvnd_in  input  N*W  dividends, requester i at bits [i*W +: W]
dvsr_in  input  N*W  divisors, same packing
ack  output  N  one-hot one-cycle pulse: operands of requester i captured
done  output  N  one-hot one-cycle pulse: result for requester i valid
quo  output  W  quotient of last completed job, held until next DONE
rmd  output  W  remainder of last completed job, held until next DONE
owner  output  $clog2(N)  index of requester currently or last served
busy  output  1  high in every state except IDLE
err  output  1  divide-by-zero flag for last job (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; ack, done, quo, rmd, owner and err all 0; busy=0.
  - Priority pointer ptr=0, so requester 0 is highest priority.
  - Any in-flight job is discarded with no done pulse. Divider core is reset too.
- FSM states are IDLE, LAUNCH, WAIT, DONE.
  - IDLE: if any req bit is set, the winner is the first set bit scanning ptr, ptr+1, ..., wrapping mod N. Latch the winner's dvnd/dvsr and owner. Next state is LAUNCH. If no req is set, stay in IDLE.
  - LAUNCH (1 cycle): ack[owner]=1; start=1 to core; next state is WAIT.
  - WAIT: stay until core done_tick=1. On done_tick, register core quo/rmd into the output regs; next state is DONE.
  - DONE (1 cycle): done[owner]=1; ptr=(owner+1) mod N; next state is IDLE.
- Core timing: start is sampled in the LAUNCH cycle, and done_tick rises exactly W+2 cycles later.
- Latency: if req is first seen in IDLE at cycle 0:
  - ack at cycle 1;
  - done at cycle W+4 (12 for W=8).
- Back-to-back throughput is one job per W+5 cycles, because of the mandatory single IDLE cycle.
- Arithmetic: unsigned; dvnd = quo*dvsr + rmd, with rmd < dvsr whenever dvsr != 0.
- Requester rules:
  - Operands are sampled only in the IDLE grant cycle. Changes after that have no effect.
  - Deasserting req before ack withdraws the request.
  - req still high after ack is treated as a new request in the next IDLE.
- Simultaneous events:
  - Multiple req bits: only the ptr-ordered winner is served; others wait, and no request is starved.
  - req arriving during busy: ignored until IDLE.
- ack and done are never both high in the same cycle, and at most one bit of each is ever set.
- quo, rmd and owner hold their value between jobs.

Optional Feature:
Macro DIV_ZERO_CHK_EN.
- Defined:
  - In IDLE, a winner with dvsr==0 skips LAUNCH/WAIT and the core start.
  - Next cycle is DONE-with-ack: ack[owner] and done[owner] pulse together, as the single exception to the ack/done exclusivity rule.
  - quo={W{1'b1}}, rmd=dvnd, err=1.
  - Any nonzero divisor job clears err=0 at its DONE.
- Not defined:
  - err is tied to 0, and dvsr==0 runs through the core normally with full latency.
  - Results are the core's natural output and are not checked by the bench.

Decomposition:
- Package div_arb_pkg: FSM state enum (IDLE, LAUNCH, WAIT, DONE) and the localparam IDX_W=$clog2(N) helper function.
- One sub-module, div_core: the iterative restoring divider with start/ready/done_tick/quo/rmd interface and the latency stated above. It is instantiated once and uses the same clk/reset polarity.
- Round-robin pick is an always_comb function inside div_arbiter, not a separate module.

Test Plan:
- Single request: W=8, N=4, req=0001, dvnd=200, dvsr=7 -> ack[0] at cycle 1, done[0] at cycle 12, quo=28, rmd=4, owner=0.
- Fairness: req=1111 held continuously after reset -> service order 0,1,2,3,0; each done spaced 13 cycles apart.
- Operand change after ack: requester 2 sends 100/9, then switches operands to 5/5 after ack -> result quo=11, rmd=1.
- Edge operands: 255/1 -> quo=255, rmd=0; 5/200 -> quo=0, rmd=5; 255/255 -> quo=1, rmd=0.
- Reset mid-WAIT: assert reset during cycle 6 of a job -> all outputs 0 immediately, no done pulse; next req=0100 is served with ptr starting at 0.
- With DIV_ZERO_CHK_EN: req[3], dvnd=77, dvsr=0 -> ack[3] and done[3] together at cycle 1, quo=255, rmd=77, err=1; a following 10/3 job returns err=0.
